data_rdbuf: RTL

- Downstream companion to the data read-request generator. Consumes its read strobe and the data block RAM read port.
- Realigns BRAM read data using a fixed-latency valid pipeline, then buffers it in a small FIFO toward the PE array (valid/ready).
- Drives back-pressure (stall) and end-of-kernel-line (end) into the request generator.

---
 rtl/data_rdbuf.sv | 89 ++++++++
 1 files changed

// File: rtl/data_rdbuf.sv
// data_rdbuf: realigns BRAM read data via a fixed-latency valid pipe and buffers it toward the PE array.
// Define DATA_RDBUF_STAT_EN to build the pop and stall statistics counters.
module data_rdbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int RD_LATENCY = 2,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rden,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [REG_WIDTH-1:0]  i_conf_linelen,
    output logic                  o_stall,
    output logic                  o_end,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [FIFO_AW:0]      o_count,
    output logic                  o_ovf,
    output logic [31:0]           o_stat_words,
    output logic [31:0]           o_stat_stall
);
    logic [RD_LATENCY-1:0] vpipe;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wptr, rptr;
    logic [FIFO_AW:0]      count;
    logic [FIFO_AW+1:0]    inflight;
    logic [15:0]           lcnt, ll;
    logic                  push, pop, full, wr, last, unused_hi;

    assign ll        = i_conf_linelen[15:0];
    assign unused_hi = ^i_conf_linelen[REG_WIDTH-1:16];
    assign push      = vpipe[RD_LATENCY-1];
    assign o_valid   = count != '0;
    assign pop       = o_valid & i_ready;
    assign full      = count == (FIFO_AW+1)'(FIFO_DEPTH);
    assign wr        = push & (~full | pop);
    assign o_data    = o_valid ? mem[rptr] : '0;
    assign o_count   = count;
    assign last      = ll <= 16'd1 || lcnt == ll - 16'd1;
    assign o_end     = i_rden & last;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++)
            inflight = inflight + (FIFO_AW+2)'(vpipe[k]);
    end

    // Counting in-flight reads lets the generator stop early enough that no pop is ever needed to avoid overflow.
    assign o_stall = ({1'b0, count} + inflight) >= (FIFO_AW+2)'(FIFO_DEPTH);

    always_ff @(posedge clk)
        if (wr) mem[wptr] <= i_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            lcnt  <= '0;
            o_ovf <= 1'b0;
        end else begin
            vpipe <= RD_LATENCY'({vpipe, i_rden});
            wptr  <= wptr + FIFO_AW'(wr);
            rptr  <= rptr + FIFO_AW'(pop);
            count <= count + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
            if (push & full & ~pop) o_ovf <= 1'b1;
            lcnt  <= o_end ? 16'd0 : lcnt + 16'(i_rden);
        end
    end

`ifdef DATA_RDBUF_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_stat_words <= '0;
            o_stat_stall <= '0;
        end else begin
            o_stat_words <= o_stat_words + 32'(pop);
            o_stat_stall <= o_stat_stall + 32'(o_stall);
        end
    end
`else
    assign o_stat_words = '0;
    assign o_stat_stall = '0;
`endif
endmodule
